mprj_io_cfg_loader: RTL and testbench

MPRJ_IO_CFG_LOADER -- requirements
Module: mprj_io_cfg_loader

---
 rtl/mprj_io_pkg.sv | 6 +
 rtl/mprj_io_cfg_clkdiv.sv | 18 +
 rtl/mprj_io_cfg_loader.sv | 102 ++++++++++
 tb/tb_mprj_io_cfg_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_io_pkg.sv
// mprj_io_pkg: shared state encoding and default chain sizes for the GPIO configuration loader
package mprj_io_pkg;
  localparam int DEF_TOTAL_PADS = 38;
  localparam int DEF_CFG_BITS = 13;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_SHIFT, ST_LATCH, ST_DONE} state_e;
endpackage

// File: rtl/mprj_io_cfg_clkdiv.sv
// mprj_io_cfg_clkdiv: phase strobe every CLK_DIV cycles, restarted by clear
module mprj_io_cfg_clkdiv #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic strobe
);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    strobe = cnt_q == 8'(CLK_DIV - 1);
    cnt_d = (clear || strobe) ? '0 : cnt_q + 8'd1;
  end
  always_ff @(posedge clock) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
endmodule

// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader: fetches per-pad config words and shifts them serially into the GPIO pad chain
module mprj_io_cfg_loader import mprj_io_pkg::*; #(
  parameter int TOTAL_PADS = DEF_TOTAL_PADS,
  parameter int CFG_BITS = DEF_CFG_BITS,
  parameter int CLK_DIV = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(TOTAL_PADS)-1:0] cfg_rd_addr,
  input  logic [CFG_BITS-1:0]           cfg_rd_data,
  output logic                          serial_clock,
  output logic                          serial_load,
  output logic                          serial_data
);
  localparam int AW = $clog2(TOTAL_PADS);
  localparam int BW = CFG_BITS > 1 ? $clog2(CFG_BITS) : 1;
  state_e state_q, state_d;
  logic [AW-1:0] pad_q, pad_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CFG_BITS-1:0] shift_q, shift_d;
  logic ph_q, ph_d;
  logic sclk_q, sclk_d, sload_q, sload_d, sdata_q, sdata_d;
  logic strobe, div_clr;
  assign div_clr = !(state_q inside {ST_SHIFT, ST_LATCH});
  mprj_io_cfg_clkdiv #(.CLK_DIV(CLK_DIV)) u_div (
    .clock(clock),
    .reset(reset),
    .clear(div_clr),
    .strobe(strobe)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pad_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      ph_q <= 1'b0;
      sclk_q <= 1'b0;
      sload_q <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q <= pad_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      ph_q <= ph_d;
      sclk_q <= sclk_d;
      sload_q <= sload_d;
      sdata_q <= sdata_d;
    end
  end
  // ph_q is the fetch cycle inside FETCH and the serial clock phase inside SHIFT
  always_comb begin
    state_d = state_q;
    pad_d = pad_q;
    bit_d = bit_q;
    shift_d = shift_q;
    ph_d = ph_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_FETCH;
        pad_d = AW'(TOTAL_PADS - 1);
      end
      ST_FETCH: begin
        ph_d = !ph_q;
        if (ph_q) begin
          state_d = ST_SHIFT;
          shift_d = cfg_rd_data;
          bit_d = BW'(CFG_BITS - 1);
        end
      end
      ST_SHIFT: if (strobe) begin
        ph_d = !ph_q;
        if (ph_q) begin
          shift_d = shift_q << 1;
          bit_d = bit_q != '0 ? bit_q - BW'(1) : bit_q;
          if (bit_q == '0) begin
            state_d = pad_q != '0 ? ST_FETCH : ST_LATCH;
            pad_d = pad_q != '0 ? pad_q - AW'(1) : pad_q;
          end
        end
      end
      ST_LATCH: state_d = strobe ? ST_DONE : ST_LATCH;
      default: state_d = ST_IDLE;
    endcase
  end
  // serial outputs are registered from next-state values so they line up with the state they belong to
  always_comb begin
    busy = state_q != ST_IDLE;
    done = state_q == ST_DONE;
    sclk_d = state_d == ST_SHIFT && ph_d;
    sload_d = state_d == ST_LATCH;
    sdata_d = shift_d[CFG_BITS-1];
  end
  assign cfg_rd_addr = pad_q;
  assign serial_clock = sclk_q;
  assign serial_load = sload_q;
  assign serial_data = sdata_q;
endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// tb_mprj_io_cfg_loader: checks two loaders (CLK_DIV 2 and 1) against a timeline model every cycle
module tb_mprj_io_cfg_loader;
  localparam logic [51:0] EXP_STREAM = {13'h1FFF, 13'h0000, 13'h1555, 13'h0803};
  logic clock, reset, start;
  logic [1:0] busy_w, done_w, sclk_w, sload_w, sdata_w;
  logic [1:0] addr_w [2];
  logic [12:0] rd_w [2];
  logic [12:0] mem [4] = '{13'h0803, 13'h1555, 13'h0000, 13'h1FFF};
  int divs [2] = '{2, 1};
  int t [2];
  bit act [2];
  int tests, fails, cyc;
  bit chk, clr_req;
  int rises [2], sload_cyc [2], done_cnt [2], cur_len [2], last_len [2];
  int min_gap [2], last_rise [2], gap_min [2], gap_max [2], idle_run [2];
  bit after_done [2], prev_sclk [2], prev_sdata [2], prev_busy [2];
  logic [51:0] cap [2];
  logic [5:0] e_v, o_v;
  bit care_v;
  logic sd_v;

  mprj_io_cfg_loader #(.TOTAL_PADS(4), .CFG_BITS(13), .CLK_DIV(2)) dut_a (
    .clock(clock), .reset(reset), .start(start), .busy(busy_w[0]), .done(done_w[0]),
    .cfg_rd_addr(addr_w[0]), .cfg_rd_data(rd_w[0]), .serial_clock(sclk_w[0]),
    .serial_load(sload_w[0]), .serial_data(sdata_w[0])
  );
  mprj_io_cfg_loader #(.TOTAL_PADS(4), .CFG_BITS(13), .CLK_DIV(1)) dut_b (
    .clock(clock), .reset(reset), .start(start), .busy(busy_w[1]), .done(done_w[1]),
    .cfg_rd_addr(addr_w[1]), .cfg_rd_data(rd_w[1]), .serial_clock(sclk_w[1]),
    .serial_load(sload_w[1]), .serial_data(sdata_w[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // configuration store with one cycle of read latency
  always @(posedge clock) begin
    rd_w[0] <= mem[addr_w[0]];
    rd_w[1] <= mem[addr_w[1]];
  end

  function automatic int len_of(input int d);
    return 4 * (2 + 2 * d * 13) + d + 1;
  endfunction

  // expected {busy, done, sclk, sload, addr} at busy cycle t of a load, from the load timeline
  function automatic void model(input int d, input int tc, input bit a,
                                output logic [5:0] e, output bit care, output logic sd);
    int per, tp, p, r, s;
    e = '0;
    care = 1'b0;
    sd = 1'b0;
    if (a) begin
      per = 2 + 2 * d * 13;
      tp = tc - 1;
      if (tp < 4 * per) begin
        p = 3 - tp / per;
        r = tp % per;
        e = {4'b1000, 2'(p)};
        if (r >= 2) begin
          s = r - 2;
          e[3] = (s % (2 * d)) >= d;
          care = 1'b1;
          sd = mem[p][12 - s / (2 * d)];
        end
      end else if (tp < 4 * per + d) e = 6'b100100;
      else e = 6'b110000;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, a, x);
    end
  endtask

  function automatic logic [6:0] obs(input int i);
    return {busy_w[i], done_w[i], sclk_w[i], sload_w[i], sdata_w[i], addr_w[i]};
  endfunction

  // model advance: a start is taken only in IDLE; the DONE cycle returns to IDLE regardless of start
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        act[i] <= 1'b0;
        t[i] <= 0;
      end else if (act[i]) begin
        act[i] <= t[i] != len_of(divs[i]);
        t[i] <= t[i] == len_of(divs[i]) ? 0 : t[i] + 1;
      end else if (start) begin
        act[i] <= 1'b1;
        t[i] <= 1;
      end
    end
  end

  always @(negedge clock) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (clr_req) begin
        rises[i] = 0; sload_cyc[i] = 0; done_cnt[i] = 0; cur_len[i] = 0; last_len[i] = 0;
        min_gap[i] = 1000; last_rise[i] = -1; gap_min[i] = 1000; gap_max[i] = 0;
        idle_run[i] = 0; after_done[i] = 1'b0; cap[i] = '0;
      end
      if (chk) begin
        model(divs[i], t[i], act[i], e_v, care_v, sd_v);
        o_v = {busy_w[i], done_w[i], sclk_w[i], sload_w[i], addr_w[i]};
        check($sformatf("dut%0d outputs t=%0d {busy,done,sclk,sload,addr}", i, t[i]), 64'(o_v), 64'(e_v));
        if (care_v) check($sformatf("dut%0d serial_data t=%0d", i, t[i]), 64'(sdata_w[i]), 64'(sd_v));
        check($sformatf("dut%0d sclk_and_sload", i), 64'(sclk_w[i] & sload_w[i]), 64'd0);
        if (prev_sclk[i] && sclk_w[i])
          check($sformatf("dut%0d sdata_stable_high", i), 64'(sdata_w[i]), 64'(prev_sdata[i]));
        if (sclk_w[i] && !prev_sclk[i]) begin
          rises[i]++;
          cap[i] = {cap[i][50:0], sdata_w[i]};
          if (last_rise[i] >= 0 && cyc - last_rise[i] < min_gap[i]) min_gap[i] = cyc - last_rise[i];
          last_rise[i] = cyc;
        end
        if (sload_w[i]) sload_cyc[i]++;
        if (done_w[i]) begin
          done_cnt[i]++;
          after_done[i] = 1'b1;
        end
        if (busy_w[i]) begin
          if (!prev_busy[i] && after_done[i]) begin
            if (idle_run[i] < gap_min[i]) gap_min[i] = idle_run[i];
            if (idle_run[i] > gap_max[i]) gap_max[i] = idle_run[i];
            after_done[i] = 1'b0;
          end
          cur_len[i]++;
          idle_run[i] = 0;
        end else begin
          idle_run[i]++;
          if (cur_len[i] != 0) last_len[i] = cur_len[i];
          cur_len[i] = 0;
        end
      end
      prev_sclk[i] = sclk_w[i];
      prev_sdata[i] = sdata_w[i];
      prev_busy[i] = busy_w[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_stats();
    clr_req = 1'b1;
    @(negedge clock);
    #1 clr_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_w != 2'b00 && n < budget) begin
      tick(1);
      n++;
    end
    if (busy_w != 2'b00) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 00", busy_w, n);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clr_req = 1'b0;
    chk = 1'b0;
    tick(1);
    chk = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) check($sformatf("dut%0d reset_state", i), 64'(obs(i)), 64'd0);
    // single load, with a second start during the load that must be dropped
    clear_stats();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(49);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(1000);
    tick(2);
    check("dut0 rises", 64'(rises[0]), 64'd52);
    check("dut1 rises", 64'(rises[1]), 64'd52);
    check("dut0 stream", 64'(cap[0]), 64'(EXP_STREAM));
    check("dut1 stream", 64'(cap[1]), 64'(EXP_STREAM));
    check("dut0 sload_cycles", 64'(sload_cyc[0]), 64'd2);
    check("dut1 sload_cycles", 64'(sload_cyc[1]), 64'd1);
    check("dut0 done_pulses", 64'(done_cnt[0]), 64'd1);
    check("dut1 done_pulses", 64'(done_cnt[1]), 64'd1);
    check("dut0 busy_len", 64'(last_len[0]), 64'd219);
    check("dut1 busy_len", 64'(last_len[1]), 64'd114);
    check("dut0 sclk_period", 64'(min_gap[0]), 64'd4);
    check("dut1 sclk_period", 64'(min_gap[1]), 64'd2);
    // reset at busy cycle 100, together with start, then a fresh load
    clear_stats();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(99);
    reset = 1'b1;
    start = 1'b1;
    tick(1);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) check($sformatf("dut%0d abort_state", i), 64'(obs(i)), 64'd0);
    tick(2);
    check("dut0 abort_no_sload", 64'(sload_cyc[0]), 64'd0);
    check("dut1 abort_no_sload", 64'(sload_cyc[1]), 64'd0);
    check("dut0 abort_idle", 64'(busy_w[0]), 64'd0);
    clear_stats();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(1000);
    tick(2);
    check("dut0 rerun_rises", 64'(rises[0]), 64'd52);
    check("dut1 rerun_rises", 64'(rises[1]), 64'd52);
    check("dut0 rerun_stream", 64'(cap[0]), 64'(EXP_STREAM));
    check("dut1 rerun_done", 64'(done_cnt[1]), 64'd1);
    check("dut0 rerun_busy_len", 64'(last_len[0]), 64'd219);
    // start held for 600 sampling edges: back-to-back loads one IDLE cycle apart
    clear_stats();
    start = 1'b1;
    tick(600);
    start = 1'b0;
    wait_idle(1000);
    tick(2);
    check("dut0 held_done_pulses", 64'(done_cnt[0]), 64'd3);
    check("dut1 held_done_pulses", 64'(done_cnt[1]), 64'd6);
    check("dut0 held_gap_min", 64'(gap_min[0]), 64'd1);
    check("dut0 held_gap_max", 64'(gap_max[0]), 64'd1);
    check("dut1 held_gap_min", 64'(gap_min[1]), 64'd1);
    check("dut1 held_gap_max", 64'(gap_max[1]), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
